// File: rtl/adder_sched_pkg.sv
// Shared types and default parameters for the adder scheduler and its arbiter.
// Optional busy counter is enabled with ADDSCHED_BUSY_CNT_EN (see adder_sched_ctrl).
package adder_sched_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_W       = 4;
    localparam int DEF_ADD_LAT = 2;
    localparam int DEF_IDW     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_sched_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping
// around to index 0.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter int N   = DEF_N,
    parameter int IDW = DEF_IDW
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] winner_o,
    output logic           any_o
);

    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [SW-1:0] idx;
    logic          found;

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = SW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                winner_o = IDW'(idx);
                found    = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/adder_sched_ctrl.sv
// Round-robin scheduler in front of one external combinational adder.
// Define ADDSCHED_BUSY_CNT_EN to add the saturating busy_cnt output.
module adder_sched_ctrl
    import adder_sched_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int ADD_LAT = DEF_ADD_LAT,
    parameter int IDW     = DEF_IDW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic [N-1:0]     gnt,
    output logic [W-1:0]    add_a,
    output logic [W-1:0]    add_b,
    input  logic [W:0]       add_sum,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDW-1:0]   resp_id,
    output logic [W:0]       resp_sum
`ifdef ADDSCHED_BUSY_CNT_EN
    ,
    output logic [15:0]      busy_cnt
`endif
);

    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [W-1:0]     add_a_q, add_a_d;
    logic [W-1:0]     add_b_q, add_b_d;
    logic             resp_valid_q, resp_valid_d;
    logic [IDW-1:0]   resp_id_q, resp_id_d;
    logic [W:0]       resp_sum_q, resp_sum_d;

    logic [IDW-1:0]   arb_win;
    logic             arb_any;

    rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (arb_win),
        .any_o    (arb_any)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        gnt_d        = '0;
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        case (state_q)
            IDLE: if (arb_any) begin
                gnt_d     = N'(1) << arb_win;
                add_a_d   = a_in[int'(arb_win)*W +: W];
                add_b_d   = b_in[int'(arb_win)*W +: W];
                resp_id_d = arb_win;
                cnt_d     = CNT_W'(ADD_LAT - 1);
            end
            WAIT: if (cnt_q == '0) begin
                resp_sum_d   = add_sum;
                resp_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            RESP: if (resp_ready) begin
                resp_valid_d = 1'b0;
                // The winner just served drops to lowest priority.
                rr_ptr_d     = (resp_id_q == IDW'(N - 1)) ? '0 : resp_id_q + IDW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            cnt_q        <= '0;
            gnt_q        <= '0;
            add_a_q      <= '0;
            add_b_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
        end
    end

    assign gnt        = gnt_q;
    assign add_a      = add_a_q;
    assign add_b      = add_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;

`ifdef ADDSCHED_BUSY_CNT_EN
    logic [15:0] busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  busy_q <= '0;
        else if (state_q != IDLE && busy_q != 16'hFFFF) busy_q <= busy_q + 16'd1;
    end

    assign busy_cnt = busy_q;
`else
    // Busy counter not built.
`endif

endmodule

// File: tb/tb_adder_sched_ctrl.sv
// Self-checking bench for adder_sched_ctrl: directed vector table, reset-abort
// sequence and randomized transactions against a round-robin reference model.
module tb_adder_sched_ctrl;
    import adder_sched_pkg::*;

    localparam int N       = DEF_N;
    localparam int W       = DEF_W;
    localparam int ADD_LAT = DEF_ADD_LAT;
    localparam int IDW     = DEF_IDW;
    localparam int AW      = N * W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [AW-1:0]  a_in, b_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   add_a, add_b;
    logic [W:0]     add_sum;
    logic           resp_valid, resp_ready;
    logic [IDW-1:0] resp_id;
    logic [W:0]     resp_sum;
`ifdef ADDSCHED_BUSY_CNT_EN
    logic [15:0]    busy_cnt;
`endif

    // The shared adder lives outside the block; model it here.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    adder_sched_ctrl #(.N(N), .W(W), .ADD_LAT(ADD_LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .a_in       (a_in),
        .b_in       (b_in),
        .gnt        (gnt),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_sum    (add_sum),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum)
`ifdef ADDSCHED_BUSY_CNT_EN
        ,
        .busy_cnt   (busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;

    typedef struct {
        logic [N-1:0]  req;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        int            id;
        logic [W:0]    sum;
        int            stall;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: first requester at or after ptr, wrapping modulo N.
    function automatic int model_pick(input logic [N-1:0] r, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic run_txn(input logic [N-1:0] r, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input int exp_id, input logic [W:0] exp_sum, input int stall);
        logic [W-1:0] ea, eb;
        ea = a[exp_id*W +: W];
        eb = b[exp_id*W +: W];
        req = r; a_in = a; b_in = b; resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("gnt", 32'(gnt), 32'(1) << exp_id);
        check("add_a", 32'(add_a), 32'(ea));
        check("add_b", 32'(add_b), 32'(eb));
        check("grant_id", 32'(resp_id), 32'(exp_id));
        check("grant_valid", 32'(resp_valid), 32'(0));
        // Inputs change freely once granted; the block must ignore them.
        req = N'($urandom); a_in = AW'($urandom); b_in = AW'($urandom);
        resp_ready = 1'($urandom_range(0, 1));
        for (int c = 0; c < ADD_LAT - 1; c++) begin
            @(posedge clk); @(negedge clk);
            check("wait_valid", 32'(resp_valid), 32'(0));
            check("wait_gnt", 32'(gnt), 32'(0));
        end
        @(posedge clk); @(negedge clk);
        check("resp_valid", 32'(resp_valid), 32'(1));
        check("resp_sum", 32'(resp_sum), 32'(exp_sum));
        check("resp_id", 32'(resp_id), 32'(exp_id));
        resp_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk);
            check("stall_valid", 32'(resp_valid), 32'(1));
            check("stall_sum", 32'(resp_sum), 32'(exp_sum));
            check("stall_id", 32'(resp_id), 32'(exp_id));
            check("stall_gnt", 32'(gnt), 32'(0));
        end
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        check("done_valid", 32'(resp_valid), 32'(0));
        check("hold_a", 32'(add_a), 32'(ea));
        check("done_gnt", 32'(gnt), 32'(0));
        model_ptr = (exp_id + 1) % N;
        req = '0;
        resp_ready = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 16'h3210, 16'h4321, 0, 5'd1,  0};
        vecs[1]  = '{4'b1111, 16'h3210, 16'h4321, 1, 5'd3,  0};
        vecs[2]  = '{4'b1111, 16'h3210, 16'h4321, 2, 5'd5,  0};
        vecs[3]  = '{4'b1111, 16'h3210, 16'h4321, 3, 5'd7,  0};
        vecs[4]  = '{4'b1111, 16'h3210, 16'h4321, 0, 5'd1,  0};
        vecs[5]  = '{4'b0001, 16'h0004, 16'h0003, 0, 5'd7,  0};
        vecs[6]  = '{4'b0100, 16'h0500, 16'h0300, 2, 5'd8,  1};
        vecs[7]  = '{4'b0100, 16'h0F00, 16'h0F00, 2, 5'd30, 0};
        vecs[8]  = '{4'b1000, 16'h9000, 16'h6000, 3, 5'd15, 5};
        vecs[9]  = '{4'b0011, 16'h00A7, 16'h00B2, 0, 5'd9,  0};
        vecs[10] = '{4'b0011, 16'h00A7, 16'h00B2, 1, 5'd21, 2};

        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; resp_ready = 1'b0;
        #12;
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_add_a", 32'(add_a), 32'(0));
        check("rst_valid", 32'(resp_valid), 32'(0));
        check("rst_sum", 32'(resp_sum), 32'(0));
`ifdef ADDSCHED_BUSY_CNT_EN
        check("rst_busy", 32'(busy_cnt), 32'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // No request: nothing moves, even with resp_ready high.
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("idle_gnt", 32'(gnt), 32'(0));
            check("idle_valid", 32'(resp_valid), 32'(0));
            check("idle_add_b", 32'(add_b), 32'(0));
        end
        resp_ready = 1'b0;

        foreach (vecs[i])
            run_txn(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].id, vecs[i].sum, vecs[i].stall);

        // Reset during WAIT aborts the transaction and clears the pointer.
        req = 4'b0001; a_in = 16'h0009; b_in = 16'h0005;
        @(posedge clk); @(negedge clk);
        check("pre_rst_gnt", 32'(gnt), 32'(1));
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_gnt", 32'(gnt), 32'(0));
        check("abort_add_a", 32'(add_a), 32'(0));
        check("abort_add_b", 32'(add_b), 32'(0));
        check("abort_valid", 32'(resp_valid), 32'(0));
        check("abort_id", 32'(resp_id), 32'(0));
        check("abort_sum", 32'(resp_sum), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < ADD_LAT + 2; i++) begin
            @(posedge clk); @(negedge clk);
            check("post_rst_valid", 32'(resp_valid), 32'(0));
        end
        run_txn(4'b1010, 16'h0030, 16'h0040, 1, 5'd7, 0);
`ifdef ADDSCHED_BUSY_CNT_EN
        check("busy_cnt", 32'(busy_cnt), 32'(3));
`endif

        for (int it = 0; it < 40; it++) begin
            logic [N-1:0]  r;
            logic [AW-1:0] a, b;
            logic [W:0]    s;
            int            id;
            r  = N'($urandom_range(1, (1 << N) - 1));
            a  = AW'($urandom);
            b  = AW'($urandom);
            id = model_pick(r, model_ptr);
            s  = {1'b0, a[id*W +: W]} + {1'b0, b[id*W +: W]};
            run_txn(r, a, b, id, s, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_sched_ctrl.md
Name: adder_sched_ctrl

Overview:
- Round-robin scheduler sharing one Delayed_Adder-style combinational adder between N requesters.
- Accepts operand pairs over a req/gnt handshake and drives the shared adder's inputs.
- Waits a fixed settle latency, captures the sum and returns it with the requester ID over a valid/ready response channel.
- Sits between requesting datapath blocks and a single adder instance.

Parameters:
- N, 4, number of requesters (2..8).
- W, 4, operand width; sum width is W+1.
- ADD_LAT, 2, settle cycles waited after operands are driven, before the sum is sampled; legal range is 1 or more.
- IDW, 2, width of resp_id; must be at least clog2(N).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N  per-requester request, level.
- a_in  in  N*W  packed operand A; slice i belongs to requester i.
- b_in  in  N*W  packed operand B.
- gnt  out  N  one-hot, one-cycle pulse marking acceptance.
- add_a  out  W  registered operand to the shared adder.
- add_b  out  W  registered operand to the shared adder.
- add_sum  in  W+1  result from the shared adder.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  requester index of the response.
- resp_sum  out  W+1  captured sum.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0 (gnt=0, add_a=0, add_b=0, resp_valid=0, resp_id=0, resp_sum=0). Internal state: state=IDLE, rr_ptr=0, wait counter=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req is nonzero at edge k, the winner is the first set bit scanning from rr_ptr upward, with wrap-around.
  - At edge k: add_a/add_b load the winner's slices, gnt[winner]=1 for exactly one cycle, resp_id=winner, counter=ADD_LAT-1, state goes to WAIT.
  - If req=0, stay in IDLE; outputs unchanged.
- WAIT:
  - If counter is 0, capture add_sum into resp_sum, set resp_valid=1, go to RESP.
  - Otherwise decrement the counter.
  - resp_valid therefore rises at edge k+ADD_LAT.
- RESP:
  - Hold resp_valid, resp_id and resp_sum stable until resp_valid and resp_ready are both high at an edge.
  - On that edge: resp_valid=0, rr_ptr=(winner+1) mod N, state goes to IDLE.
  - A new grant can occur on the next edge at the earliest, so there is one IDLE cycle between operations.
- Operand handling:
  - add_a/add_b hold the granted operands until the next grant; they do not return to 0.
  - The requester must hold req, a_in and b_in stable until it sees gnt, and may drop req afterwards.
  - Changes to req, a_in or b_in during WAIT or RESP are ignored.
- Arithmetic: no arithmetic inside the block. resp_sum is add_sum taken verbatim (W+1 bits), so the carry-out is preserved (15+15 gives 30).
- Fairness: the requester just served has lowest priority in the next arbitration. A requester still holding req after its response is served again only if no other req is set.
- Reset mid-operation: the transaction is aborted and no response is issued. Everything returns to reset values immediately and asynchronously.
- resp_ready high while not in RESP: no effect.

Optional Feature:
- Macro ADDSCHED_BUSY_CNT_EN.
- Defined: adds output busy_cnt [15:0], reset to 0. It increments every cycle the state is not IDLE and saturates at 16'hFFFF.
- Not defined: the port is absent, with no extra logic.

Decomposition:
- Package adder_sched_pkg holds:
  - the state encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - the default W/N/ADD_LAT constants.
- Sub-module rr_arbiter (combinational): inputs req[N] and rr_ptr; outputs the winner index and an any-request flag.
- rr_ptr is held in adder_sched_ctrl.
- The adder itself stays external.

Test Plan:
- Single request, a=4, b=3 on requester 0, ADD_LAT=2, resp_ready=1 → gnt=4'b0001 for one cycle; resp_valid 2 cycles later; resp_sum=7; resp_id=0.
- Requester 2 with a=5, b=3, then requester 2 with a=15, b=15 → resp_sum=8, then resp_sum=30 (carry kept).
- req=4'b1111 held with operands i, i+1 and resp_ready=1 → grant order 0,1,2,3,0; sums 1,3,5,7,1.
- resp_ready=0 for 5 cycles during RESP with a=9, b=6 → resp_valid, resp_sum=15 and resp_id stable all 5 cycles; no new gnt. Release → single handshake, then return to IDLE.
- rst_n pulsed low during WAIT → all outputs 0 asynchronously; no resp_valid afterward; rr_ptr=0, so the next req=4'b1010 grants requester 1.
- With ADDSCHED_BUSY_CNT_EN defined and one transaction of ADD_LAT=2 plus 1 RESP cycle → busy_cnt=3.
